// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 divider (a / b): restoring mantissa division, one quotient bit per cycle, RNE rounding.
// Latency: start accepted at edge k -> done high in the cycle after edge k+MAN_W+5; result/flags held until next done.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped (no queueing).
// Ports: clk, rst_n (async active-low); start/op_a/op_b request; busy/done status;
//        result plus invalid/div_by_zero/overflow/underflow flags.
module fp_divider_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   invalid,
    output logic                   div_by_zero,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int SIG_W = MAN_W + 1;          // significand incl. hidden bit
    localparam int REM_W = MAN_W + 2;          // remainder stays below 2*divisor
    localparam int Q_W   = MAN_W + 3;          // integer + fraction + guard + round
    localparam int E_W   = EXP_W + 2;          // two guard bits, two's complement
    localparam int CNT_W = $clog2(Q_W);

    localparam logic [E_W-1:0]   BIAS    = E_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [E_W-1:0]   EXP_MAX = E_W'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(Q_W - 1);
    localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_ROUND, S_DONE} state_t;

    state_t state, state_nxt;

    // operand capture and datapath state
    logic [W-1:0]     a_q, b_q;
    logic             sign_q;
    logic [E_W-1:0]   exp_q;
    logic [REM_W-1:0] rem_q;
    logic [SIG_W-1:0] dvs_q;
    logic [Q_W-1:0]   quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             spec_q;
    logic [W-1:0]     spec_res_q;
    logic             spec_inv_q, spec_dbz_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE:  begin
                busy = 1'b0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD:  state_nxt = S_DIV;
            S_DIV:   if (cnt_q == LAST) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_DONE;
            S_DONE:  begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- LOAD: unpack / classify ----------------
    logic               sa, sb, sgn;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [SIG_W-1:0]   ma, mb;
    logic [E_W-1:0]     exp_raw;
    logic               a_lt_b;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign sgn    = sa ^ sb;
    // exponent field 0 is treated as zero, so denormal inputs flush
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign ma     = a_zero ? '0 : {1'b1, fa};
    assign mb     = b_zero ? '0 : {1'b1, fb};
    assign exp_raw = E_W'(ea) - E_W'(eb) + BIAS;
    assign a_lt_b  = (ma < mb);

    logic         spec;
    logic [W-1:0] spec_res;
    logic         spec_inv, spec_dbz;

    always_comb begin
        spec     = 1'b1;
        spec_res = '0;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_dbz = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_res = {sgn, {(W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    // ---------------- DIV: one restoring step ----------------
    logic             q_bit;
    logic [REM_W-1:0] rem_sub, rem_keep, rem_next;

    assign q_bit    = (rem_q >= REM_W'(dvs_q));
    assign rem_sub  = rem_q - REM_W'(dvs_q);
    assign rem_keep = q_bit ? rem_sub : rem_q;
    // rem_keep < divisor < 2^SIG_W, so its top bit is always 0 and the shift loses nothing
    assign rem_next = {rem_keep[REM_W-2:0], 1'b0};

    // ---------------- ROUND: RNE, renormalise, range check ----------------
    logic             guard, sticky, rnd_up, carry;
    logic [SIG_W:0]   mant_r;
    logic [MAN_W-1:0] frac_r;
    logic [E_W-1:0]   exp_r;
    logic             ovf, unf;

    assign guard  = quo_q[1];
    assign sticky = quo_q[0] | (rem_q != '0);
    assign rnd_up = guard & (sticky | quo_q[2]);
    assign mant_r = {1'b0, quo_q[Q_W-1:2]} + (SIG_W+1)'(rnd_up);
    assign carry  = mant_r[SIG_W];
    assign frac_r = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    assign exp_r  = exp_q + E_W'(carry);
    assign ovf    = $signed(exp_r) >= $signed(EXP_MAX);
    assign unf    = $signed(exp_r) <= $signed(E_W'(0));

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_inv_q  <= 1'b0;
            spec_dbz_q  <= 1'b0;
            result      <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_q         <= op_a;
                    b_q         <= op_b;
                    invalid     <= 1'b0;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                end
                S_LOAD: begin
                    sign_q     <= sgn;
                    dvs_q      <= mb;
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    spec_q     <= spec;
                    spec_res_q <= spec_res;
                    spec_inv_q <= spec_inv;
                    spec_dbz_q <= spec_dbz;
                    // pre-scale the dividend so the quotient lands in [1,2)
                    if (a_lt_b) begin
                        rem_q <= {ma, 1'b0};
                        exp_q <= exp_raw - E_W'(1);
                    end else begin
                        rem_q <= {1'b0, ma};
                        exp_q <= exp_raw;
                    end
                end
                S_DIV: begin
                    quo_q <= {quo_q[Q_W-2:0], q_bit};
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_ROUND: begin
                    if (spec_q) begin
                        result      <= spec_res_q;
                        invalid     <= spec_inv_q;
                        div_by_zero <= spec_dbz_q;
                    end else if (ovf) begin
                        result   <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        overflow <= 1'b1;
                    end else if (unf) begin
                        result    <= {sign_q, {(W-1){1'b0}}};
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_q, exp_r[EXP_W-1:0], frac_r};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed bench for fp_divider_seq: expected results queued at request time, popped on done.
// Latency: every request is expected to complete 28 cycles after its accepting edge.
// Backpressure: exercises ignored starts while busy, back-to-back requests and mid-operation reset.
module tb_fp_divider_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;
    logic        invalid, div_by_zero, overflow, underflow;

    logic [3:0]  flags;
    assign flags = {invalid, div_by_zero, overflow, underflow};

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_DBZ  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;
    localparam int         LAT    = 28;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] prev_res = '0;

    fp_divider_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .invalid     (invalid),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one request, optionally pulsing start again while busy, then compare against the queue.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, input bit extra_starts);
        exp_t e;
        int   lat;
        int   ndone;
        bit   got;
        sb_q.push_back('{res: er, fl: ef});
        @(negedge clk);
        chk("done_single_cycle", done, 0);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        got   = 0;
        lat   = -1;
        ndone = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (extra_starts && (n == 2 || n == 26)) start = 1'b1;
            // operands are don't-care once captured
            op_a = $urandom;
            op_b = $urandom;
            if (n == 0) begin
                chk("busy_after_accept", busy, 1);
                chk("flags_cleared_on_accept", flags, 0);
                chk("result_held_until_done", result, prev_res);
            end
            if (done) begin
                ndone++;
                got = 1;
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        e = sb_q.pop_front();
        if (got) begin
            chk("latency", lat, LAT);
            chk("done_pulses", ndone, 1);
            chk("result", result, e.res);
            chk("flags", flags, e.fl);
            chk("busy_with_done", busy, 1);
        end
        prev_res = e.res;
    endtask

    initial begin
        int nd;
        // reset state
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", flags, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // basic function
        do_op(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 0);
        do_op(32'hC0C00000, 32'h40000000, 32'hC0400000, F_NONE, 0);
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NONE, 0);
        do_op(32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, F_NONE, 0);

        // specials
        do_op(32'h3F800000, 32'h00000000, 32'h7F800000, F_DBZ,  0);
        do_op(32'h00000000, 32'h00000000, 32'h7FC00000, F_INV,  0);
        do_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, F_INV,  0);
        do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_NONE, 0);
        do_op(32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, 0);
        do_op(32'h80000000, 32'h7F800000, 32'h80000000, F_NONE, 0);

        // range limits
        do_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, F_OVF,  0);
        do_op(32'h00800000, 32'h40000000, 32'h00000000, F_UNF,  0);
        do_op(32'h00000001, 32'h3F800000, 32'h00000000, F_NONE, 0);

        // handshake: spurious starts while busy, then immediate back-to-back request
        do_op(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 1);
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NONE, 0);

        // reset in the middle of an operation
        @(negedge clk);
        op_a  = 32'h40C00000;
        op_b  = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", flags, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        prev_res = '0;
        nd = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_abort", nd, 0);
        do_op(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_divider_seq.md
Name: fp_divider_seq

Overview:
Sequential IEEE-754 floating-point divider that computes a / b and produces one result per request. It uses a start/busy/done handshake and an iterative restoring mantissa division that produces one quotient bit per cycle. It sits alongside the combinational floating-point multiplier in the arithmetic datapath, registers its operands on start, and holds its result until the next completion.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
MAN_W, 23, stored fraction width. Quotient iterations = MAN_W+3. Total latency = MAN_W+6 cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
op_a  input  EXP_W+MAN_W+1  dividend, {sign, exponent, fraction}
op_b  input  EXP_W+MAN_W+1  divisor
busy  output  1  high from the cycle after start is accepted until done drops
done  output  1  one-cycle pulse; result and flags are valid and held after it
result  output  EXP_W+MAN_W+1  quotient
invalid  output  1  0/0 or inf/inf
div_by_zero  output  1  finite nonzero / 0
overflow  output  1  result saturated to infinity
underflow  output  1  result flushed to zero

Behaviour:
- Reset is asynchronous with rst_n=0. State goes to IDLE. busy, done, result and all flags go to 0. Reset mid-operation aborts the operation with no done.
- State machine: IDLE -> LOAD -> DIV -> ROUND -> DONE -> IDLE.
  - IDLE: if start=1 at a clock edge, capture op_a and op_b and go to LOAD.
  - LOAD: one cycle. Unpack operands, append the hidden 1, and treat exponent field 0 as zero (denormal inputs flush to zero). Classify specials. Compute sign = sa^sb and exp = ea-eb+bias with 2 guard bits, signed. If mant_a < mant_b, double the dividend and decrement exp, so the quotient lies in [1,2).
  - DIV: exactly MAN_W+3 cycles, one restoring step per cycle. Produces 24 quotient bits, then guard, then round (for default widths). A counter counts 0..MAN_W+2.
  - ROUND: sticky = (remainder != 0) | round. Round to nearest, ties to even. A mantissa carry renormalises and increments exp. Then:
    - exp >= 2^EXP_W-1: result = ±inf, overflow=1.
    - exp <= 0: result = ±0, underflow=1 (no denormal outputs).
  - DONE: done=1 for exactly one cycle. result and flags are registered outputs updated on entry to DONE and held until the next DONE. Flags are cleared when the next request is accepted.
- Timing: start accepted at edge k -> done high in the cycle after edge k+MAN_W+5 (k+28 for defaults). busy is high from edge k+1 until done falls.
- Specials are resolved in LOAD but still take the full fixed latency. Priority, highest first:
  1. Either operand NaN -> canonical qNaN {0, all-ones exp, 1, zeros}; no flag.
  2. 0/0 or inf/inf -> qNaN, invalid=1.
  3. inf/x -> ±inf.
  4. x/0 with x finite nonzero -> ±inf, div_by_zero=1.
  5. 0/x or x/inf -> ±0.
  Signs are computed as sa^sb except for NaN.
- start while busy is ignored; no queueing. A start held high in the same cycle as done is not accepted until IDLE is reached.
- Combinational logic does not depend on op_a or op_b after LOAD, so inputs may change freely while busy.

Test Plan:
1. 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, all flags 0, done exactly 28 cycles after the accepting edge. Then 0xC0C00000 / 0x40000000 -> 0xC0400000.
2. 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round up via sticky). Also 0x3F800000 / 0x3F800001 -> 0x3F7FFFFE (RNE).
3. Specials:
   - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
   - 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1.
   - 0x7F800000 / 0xFF800000 -> 0x7FC00000, invalid=1.
   - 0x7FC00001 / 0x3F800000 -> 0x7FC00000, no flag.
4. Range:
   - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow=1.
   - 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
   - Denormal 0x00000001 / 0x3F800000 -> 0x00000000.
5. Handshake: start pulses again at cycles +3 and +27 while busy -> ignored, single done pulse, result unchanged. start asserted the cycle after done -> new operation accepted, busy back-to-back.
6. Reset: assert rst_n=0 at cycle +10 of an operation -> busy, done, result and flags go to 0 immediately, no done follows. A fresh 6.0/2.0 request after release completes correctly.
